// File: rtl/ex_exec_core.sv
// Execute-stage compute core: 32-bit ALU with address adder, branch-condition
// evaluator and data-memory access unit with a registered read word.
module ex_exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  sa,
    input  logic [2:0]  branch_type,
    input  logic        mem_write,
    input  logic        is_byte,
    input  logic        is_half,
    input  logic [31:0] store_data,
    output logic [31:0] alu_c,
    output logic [31:0] alu_sum,
    output logic        alu_zero,
    output logic        branch_avail,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        misalign,
    output logic [31:0] dm_out
);

    logic [31:0] alu_c_s;
    logic        branch_s;
    logic [3:0]  be_lanes_s;
    logic        misalign_s;
    logic [31:0] wdata_s;
    logic [1:0]  addr_lo_s;
    logic [31:0] dm_out_r;

    // The memory address adder runs regardless of alu_op.
    assign alu_sum   = rd1 + alu_b;
    assign addr_lo_s = alu_sum[1:0];

    // ALU function select.
    always_comb begin
        alu_c_s = 32'd0;
        case (alu_op)
            4'd0:    alu_c_s = rd1 + alu_b;
            4'd1:    alu_c_s = rd1 - alu_b;
            4'd2:    alu_c_s = rd1 & alu_b;
            4'd3:    alu_c_s = rd1 | alu_b;
            4'd4:    alu_c_s = rd1 ^ alu_b;
            4'd5:    alu_c_s = ~(rd1 | alu_b);
            4'd6:    alu_c_s = alu_b << sa;
            4'd7:    alu_c_s = alu_b >> sa;
            4'd8:    alu_c_s = $signed(alu_b) >>> sa;
            4'd9:    alu_c_s = alu_b << rd1[4:0];
            4'd10:   alu_c_s = alu_b >> rd1[4:0];
            4'd11:   alu_c_s = $signed(alu_b) >>> rd1[4:0];
            4'd12:   alu_c_s = {alu_b[15:0], 16'd0};
            4'd13:   alu_c_s = alu_b;
            4'd14:   alu_c_s = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd15:   alu_c_s = (rd1 < alu_b) ? 32'd1 : 32'd0;
            default: alu_c_s = 32'd0;
        endcase
    end

    assign alu_c    = alu_c_s;
    assign alu_zero = (alu_c_s == 32'd0);

    // Branch condition evaluation; zero compares are signed on rd1.
    always_comb begin
        branch_s = 1'b0;
        case (branch_type)
            3'd0:    branch_s = 1'b0;
            3'd1:    branch_s = (rd1 == rd2);
            3'd2:    branch_s = (rd1 != rd2);
            3'd3:    branch_s = rd1[31] || (rd1 == 32'd0);
            3'd4:    branch_s = !rd1[31] && (rd1 != 32'd0);
            3'd5:    branch_s = rd1[31];
            3'd6:    branch_s = !rd1[31];
            3'd7:    branch_s = 1'b1;
            default: branch_s = 1'b0;
        endcase
    end

    assign branch_avail = branch_s;

    // Lane enables, lane replication and alignment by access size.
    always_comb begin
        be_lanes_s = 4'b0000;
        misalign_s = 1'b0;
        wdata_s    = 32'd0;
        if (is_byte) begin
            be_lanes_s = 4'b0001 << addr_lo_s;
            misalign_s = 1'b0;
            wdata_s    = {4{store_data[7:0]}};
        end else if (is_half) begin
            be_lanes_s = addr_lo_s[1] ? 4'b1100 : 4'b0011;
            misalign_s = addr_lo_s[0];
            wdata_s    = {2{store_data[15:0]}};
        end else begin
            be_lanes_s = 4'b1111;
            misalign_s = (addr_lo_s != 2'b00);
            wdata_s    = store_data;
        end
    end

    assign bus_addr  = {alu_sum[31:2], 2'b00};
    assign misalign  = misalign_s;
    assign bus_be    = misalign_s ? 4'b0000 : be_lanes_s;
    assign bus_we    = mem_write && !misalign_s;
    assign bus_wdata = wdata_s;

    // Read word register feeding the MEM stage; raw word, no extension.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_out_r <= 32'd0;
        end else begin
            dm_out_r <= bus_rdata;
        end
    end

    assign dm_out = dm_out_r;

endmodule

// File: tb/tb_ex_exec_core.sv
// Self-checking bench for ex_exec_core: directed test-plan steps followed by
// randomized vectors compared against an arithmetic reference model.
module tb_ex_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd1, rd2, alu_b, store_data, bus_rdata;
    logic [3:0]  alu_op;
    logic [4:0]  sa;
    logic [2:0]  branch_type;
    logic        mem_write, is_byte, is_half;
    logic [31:0] alu_c, alu_sum, bus_addr, bus_wdata, dm_out;
    logic        alu_zero, branch_avail, bus_we, misalign;
    logic [3:0]  bus_be;

    int tests = 0;
    int fails = 0;

    ex_exec_core dut (
        .clk(clk), .rst(rst), .rd1(rd1), .rd2(rd2), .alu_b(alu_b),
        .alu_op(alu_op), .sa(sa), .branch_type(branch_type),
        .mem_write(mem_write), .is_byte(is_byte), .is_half(is_half),
        .store_data(store_data), .alu_c(alu_c), .alu_sum(alu_sum),
        .alu_zero(alu_zero), .branch_avail(branch_avail), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .misalign(misalign), .dm_out(dm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_lsl(input logic [31:0] b, input int n);
        logic [63:0] p;
        p = {32'd0, b} * (64'd1 << n);
        return p[31:0];
    endfunction

    function automatic logic [31:0] m_lsr(input logic [31:0] b, input int n);
        return b / (32'd1 << n);
    endfunction

    function automatic logic [31:0] m_asr(input logic [31:0] b, input int n);
        return b[31] ? ~m_lsr(~b, n) : m_lsr(b, n);
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] s);
        longint sa_l, sb_l, ua_l, ub_l;
        int n;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        ua_l = longint'({32'd0, a});
        ub_l = longint'({32'd0, b});
        n = int'(a % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + (~b) + 32'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return m_lsl(b, int'(s));
            4'd7:    return m_lsr(b, int'(s));
            4'd8:    return m_asr(b, int'(s));
            4'd9:    return m_lsl(b, n);
            4'd10:   return m_lsr(b, n);
            4'd11:   return m_asr(b, n);
            4'd12:   return m_lsl(b, 16);
            4'd13:   return b;
            4'd14:   return (sa_l < sb_l) ? 32'd1 : 32'd0;
            default: return (ua_l < ub_l) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic m_branch(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        longint v;
        v = longint'($signed(a));
        case (t)
            3'd0:    return 1'b0;
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return v <= 0;
            3'd4:    return v > 0;
            3'd5:    return v < 0;
            3'd6:    return v >= 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic m_access(input logic [31:0] addr, input logic byt, input logic hlf,
                            input logic wr, input logic [31:0] sd,
                            output logic [3:0] be, output logic [31:0] wd,
                            output logic mis, output logic we);
        int size, off, lanes;
        size  = byt ? 1 : (hlf ? 2 : 4);
        off   = int'(addr % 4);
        mis   = (off % size) != 0;
        lanes = ((1 << size) - 1) << off;
        be    = mis ? 4'b0000 : lanes[3:0];
        we    = wr && !mis;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_c, e_sum, e_wd;
        logic [3:0]  e_be;
        logic        e_mis, e_we;
        e_c   = m_alu(alu_op, rd1, alu_b, sa);
        e_sum = rd1 + alu_b;
        m_access(e_sum, is_byte, is_half, mem_write, store_data, e_be, e_wd, e_mis, e_we);
        chk({tag, ".alu_c"}, alu_c, e_c);
        chk({tag, ".alu_zero"}, {31'd0, alu_zero}, {31'd0, e_c == 32'd0});
        chk({tag, ".alu_sum"}, alu_sum, e_sum);
        chk({tag, ".bus_addr"}, bus_addr, e_sum & 32'hFFFF_FFFC);
        chk({tag, ".branch"}, {31'd0, branch_avail}, {31'd0, m_branch(branch_type, rd1, rd2)});
        chk({tag, ".be"}, {28'd0, bus_be}, {28'd0, e_be});
        chk({tag, ".wdata"}, bus_wdata, e_wd);
        chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
        chk({tag, ".we"}, {31'd0, bus_we}, {31'd0, e_we});
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] rdata_v;

    initial begin
        rst = 1'b1; rd1 = 32'd0; rd2 = 32'd0; alu_b = 32'd0; alu_op = 4'd0; sa = 5'd0;
        branch_type = 3'd0; mem_write = 1'b0; is_byte = 1'b0; is_half = 1'b0;
        store_data = 32'd0; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("reset.dm_out", dm_out, 32'd0);
        @(posedge clk); #1;
        chk("reset.hold", dm_out, 32'd0);
        @(negedge clk); rst = 1'b0;

        // ALU directed
        rd1 = 32'hFFFF_FFFF; alu_b = 32'd1; alu_op = 4'd0; #1;
        chk("add.c", alu_c, 32'd0);
        chk("add.zero", {31'd0, alu_zero}, 32'd1);
        alu_op = 4'd1; #1;  chk("sub", alu_c, 32'hFFFF_FFFE);
        alu_op = 4'd14; #1; chk("slt", alu_c, 32'd1);
        alu_op = 4'd15; #1; chk("sltu", alu_c, 32'd0);
        alu_b = 32'h8000_0000; sa = 5'd4;
        alu_op = 4'd7; #1;  chk("srl", alu_c, 32'h0800_0000);
        alu_op = 4'd8; #1;  chk("sra", alu_c, 32'hF800_0000);
        alu_b = 32'd1; sa = 5'd31; alu_op = 4'd6; #1; chk("sll31", alu_c, 32'h8000_0000);
        alu_b = 32'h1234; alu_op = 4'd12; #1; chk("lui", alu_c, 32'h1234_0000);
        alu_b = 32'hA5A5_0F0F; sa = 5'd0; alu_op = 4'd8; #1; chk("sra0", alu_c, 32'hA5A5_0F0F);

        // Branch directed
        rd1 = 32'd5; rd2 = 32'd5;
        branch_type = 3'd1; #1; chk("beq", {31'd0, branch_avail}, 32'd1);
        branch_type = 3'd2; #1; chk("bne", {31'd0, branch_avail}, 32'd0);
        rd1 = 32'h8000_0000;
        branch_type = 3'd3; #1; chk("blez", {31'd0, branch_avail}, 32'd1);
        branch_type = 3'd4; #1; chk("bgtz", {31'd0, branch_avail}, 32'd0);
        branch_type = 3'd5; #1; chk("bltz", {31'd0, branch_avail}, 32'd1);
        branch_type = 3'd6; #1; chk("bgez", {31'd0, branch_avail}, 32'd0);
        branch_type = 3'd0; #1; chk("bnone", {31'd0, branch_avail}, 32'd0);
        branch_type = 3'd7; #1; chk("bjump", {31'd0, branch_avail}, 32'd1);
        rd1 = 32'd0; branch_type = 3'd3; #1; chk("blez0", {31'd0, branch_avail}, 32'd1);
        branch_type = 3'd4; #1; chk("bgtz0", {31'd0, branch_avail}, 32'd0);

        // Store directed
        rd1 = 32'h100; alu_b = 32'd3; is_byte = 1'b1; mem_write = 1'b1;
        store_data = 32'hAABB_CCDD; #1;
        chk("sb.be", {28'd0, bus_be}, 32'b1000);
        chk("sb.wdata", bus_wdata, 32'hDDDD_DDDD);
        chk("sb.we", {31'd0, bus_we}, 32'd1);
        chk("sb.addr", bus_addr, 32'h100);
        is_byte = 1'b0; is_half = 1'b1; alu_b = 32'd2; #1;
        chk("sh.be", {28'd0, bus_be}, 32'b1100);
        chk("sh.wdata", bus_wdata, 32'hCCDD_CCDD);
        is_half = 1'b0; alu_b = 32'd1; #1;
        chk("sw.mis", {31'd0, misalign}, 32'd1);
        chk("sw.we", {31'd0, bus_we}, 32'd0);
        chk("sw.be", {28'd0, bus_be}, 32'd0);
        is_half = 1'b1; alu_b = 32'd3; #1;
        chk("sh3.mis", {31'd0, misalign}, 32'd1);
        is_byte = 1'b1; mem_write = 1'b0; #1;
        chk("lb.mis", {31'd0, misalign}, 32'd0);
        chk("lb.we", {31'd0, bus_we}, 32'd0);
        chk("lb.be", {28'd0, bus_be}, 32'b1000);

        // dm_out latency and asynchronous reset
        @(negedge clk); bus_rdata = 32'h1234_5678; #1;
        chk("dm.before", dm_out, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("dm.after", dm_out, 32'h1234_5678);
        #2; rst = 1'b1; #1;
        chk("dm.async_rst", dm_out, 32'd0);
        @(posedge clk); #1;
        chk("dm.rst_hold", dm_out, 32'd0);
        @(negedge clk); rst = 1'b0; bus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("dm.reload", dm_out, 32'hCAFE_F00D);

        // Randomized vectors against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rd1 = pick32();
            rd2 = ($urandom_range(0, 3) == 0) ? rd1 : pick32();
            alu_b = ($urandom_range(0, 4) == 0) ? rd1 : pick32();
            alu_op = 4'($urandom_range(0, 15));
            sa = 5'($urandom_range(0, 31));
            branch_type = 3'($urandom_range(0, 7));
            mem_write = 1'($urandom_range(0, 1));
            is_byte = 1'($urandom_range(0, 1));
            is_half = 1'($urandom_range(0, 1));
            store_data = $urandom;
            rdata_v = $urandom;
            bus_rdata = rdata_v;
            #1;
            check_all($sformatf("rnd%0d", i));
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.dm_out", i), dm_out, rdata_v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_exec_core.md
Name: ex_exec_core

Overview:
- Execute-stage compute core for the MIPS-style pipeline. It combines three functions:
  - a 32-bit ALU (arithmetic, logic, shift, compare) with a dedicated address adder;
  - a branch-condition evaluator;
  - a data-memory access unit that drives store byte-enables and registers the returned read word for the MEM stage.
- Everything is combinational except the read-data register.

Parameters:
- None. All widths are fixed: 32-bit data, 5-bit shift amount.

Ports:
- clk  in  1  clock; the only edge used is posedge
- rst  in  1  asynchronous, active-high reset
- rd1  in  32  forwarded rs value; ALU operand A and branch operand 1
- rd2  in  32  forwarded rt value; branch operand 2
- alu_b  in  32  ALU operand B (rt or extended immediate, muxed upstream)
- alu_op  in  4  ALU function select
- sa  in  5  instruction shift amount
- branch_type  in  3  branch condition select
- mem_write  in  1  store request this cycle
- is_byte  in  1  byte access
- is_half  in  1  halfword access; ignored when is_byte=1
- store_data  in  32  forwarded store value
- alu_c  out  32  ALU result
- alu_sum  out  32  rd1+alu_b modulo 2^32, independent of alu_op (memory address)
- alu_zero  out  1  alu_c==0
- branch_avail  out  1  branch condition true
- bus_addr  out  32  alu_sum with bits [1:0] forced to 0
- bus_we  out  1  store strobe
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  word returned combinationally by memory/bridge for bus_addr
- misalign  out  1  access address is misaligned for its size
- dm_out  out  32  registered bus_rdata

Behaviour:
ALU, alu_c by alu_op:
- 0 A+B (no overflow trap); 1 A-B; 2 A&B; 3 A|B; 4 A^B; 5 ~(A|B).
- 6 B<<sa; 7 B>>sa logical; 8 B>>>sa arithmetic.
- 9 B<<A[4:0]; 10 B>>A[4:0] logical; 11 B>>>A[4:0] arithmetic.
- 12 B<<16 (LUI); 13 B (pass-through).
- 14 signed A<B ? 1 : 0; 15 unsigned A<B ? 1 : 0.
- All results wrap modulo 2^32.
- A shift of 0 returns B unchanged. Shift counts are 5 bits, so they never reach 32.

Branch, branch_avail by branch_type (signed compares on rd1):
- 0 none -> 0; 1 BEQ rd1==rd2; 2 BNE rd1!=rd2.
- 3 BLEZ rd1<=0; 4 BGTZ rd1>0; 5 BLTZ rd1<0; 6 BGEZ rd1>=0.
- 7 unconditional -> 1.

Access (combinational from alu_sum low bits a=alu_sum[1:0]):
- Byte access:
  - bus_be = 4'b0001 << a.
  - bus_wdata = store_data[7:0] replicated 4 times.
  - Never misaligned.
- Half access:
  - bus_be = a[1] ? 4'b1100 : 4'b0011.
  - bus_wdata = store_data[15:0] replicated 2 times.
  - misalign = a[0].
- Word access:
  - bus_be = 4'b1111.
  - bus_wdata = store_data.
  - misalign = (a!=0).
- bus_we = mem_write & !misalign.
- When misalign=1: bus_be=0 and no write occurs.
- misalign is reported whenever the size/address combination is misaligned, independent of mem_write.
- When mem_write=0: bus_be still reflects the access size (read lanes), and bus_we=0.

dm_out:
- dm_out <= bus_rdata on every posedge clk, giving one cycle of latency to the MEM stage.
- dm_out is the raw word; no load extension here (MEM stage extends).
- On rst assertion, dm_out = 0 immediately (asynchronous) and holds 0 while rst=1.
- Combinational outputs are unaffected by rst.
- A store and a read of the same address in the same cycle: dm_out captures whatever bus_rdata presents (old data for synchronous-write memory).

Test Plan:
- ALU: rd1=0xFFFFFFFF, alu_b=1, op0 -> alu_c=0, alu_zero=1; op1 -> 0xFFFFFFFE; op14 -> 1; op15 -> 0.
- Shifts: alu_b=0x80000000, sa=4. op7 -> 0x08000000; op8 -> 0xF8000000; op6 with alu_b=1, sa=31 -> 0x80000000; op12 with alu_b=0x1234 -> 0x12340000.
- Branch:
  - rd1=rd2=5: type1 -> 1, type2 -> 0.
  - rd1=0x80000000: type3 -> 1, type4 -> 0, type5 -> 1, type6 -> 0.
  - type0 -> 0; type7 -> 1.
- Store:
  - rd1=0x100, alu_b=3, is_byte, mem_write, store_data=0xAABBCCDD -> bus_be=1000, bus_wdata=0xDDDDDDDD, bus_we=1, bus_addr=0x100.
  - Same inputs with is_half at addr 0x102 -> be=1100, wdata=0xCCDDCCDD.
- Misalign: word store at 0x101 -> misalign=1, bus_we=0, bus_be=0. Half store at 0x103 -> misalign=1.
- dm_out:
  - bus_rdata=0x12345678 -> dm_out updates after the next posedge.
  - Assert rst mid-cycle -> dm_out=0 without a clock edge; deassert, next edge loads bus_rdata.
